// File: rtl/rgb_fade_ctrl_pkg.sv
// rgb_pkg: shared definitions for the RGB fade controller.
//   PWM_BITS  - width of PWM counter and intensities
//   RATE_BITS - width of the fade-rate field
//   LED_OFF   - pin level that keeps an active-low LED dark
//   fade_state_t - controller FSM encoding
//   fade_step - one linear fade step of a channel toward its target
package rgb_pkg;

    localparam int PWM_BITS  = 8;
    localparam int RATE_BITS = 4;
    localparam logic LED_OFF = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } fade_state_t;

    // Move cur toward tgt by rate, landing exactly on tgt when within reach.
    // 9-bit arithmetic so neither direction can wrap.
    function automatic logic [PWM_BITS-1:0] fade_step(
        input logic [PWM_BITS-1:0]  cur,
        input logic [PWM_BITS-1:0]  tgt,
        input logic [RATE_BITS-1:0] rate
    );
        logic [PWM_BITS:0] c9;
        logic [PWM_BITS:0] t9;
        logic [PWM_BITS:0] r9;
        logic [PWM_BITS:0] diff;
        logic [PWM_BITS:0] res;
        c9 = {1'b0, cur};
        t9 = {1'b0, tgt};
        r9 = {{(PWM_BITS + 1 - RATE_BITS){1'b0}}, rate};
        diff = (t9 >= c9) ? (t9 - c9) : (c9 - t9);
        if (diff <= r9)
            res = t9;
        else if (t9 > c9)
            res = c9 + r9;
        else
            res = c9 - r9;
        return res[PWM_BITS-1:0];
    endfunction

endpackage

// File: rtl/rgb_fade_ctrl_if.sv
// rgb_fade_ctrl_if: colour command valid/ready channel.
//   cmd_valid/cmd_ready - handshake
//   cmd_r/g/b           - target intensities (0 off, 255 max)
//   cmd_rate            - fade step per PWM period, 0 = immediate jump
//   master: command source; slave: rgb_fade_ctrl
interface rgb_fade_ctrl_if;
    import rgb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [PWM_BITS-1:0]  cmd_r;
    logic [PWM_BITS-1:0]  cmd_g;
    logic [PWM_BITS-1:0]  cmd_b;
    logic [RATE_BITS-1:0] cmd_rate;

    modport master (
        output cmd_valid, cmd_r, cmd_g, cmd_b, cmd_rate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_r, cmd_g, cmd_b, cmd_rate,
        output cmd_ready
    );

endinterface

// File: rtl/rgb_fade_ctrl_pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit PWM counter.
//   clk, rst (async active-low)
//   pwm_cnt - advances once every TICK_DIV clocks, wraps 255->0
//   wrap    - high in the clock whose edge ends a PWM period
module pwm_timebase
    import rgb_pkg::*;
#(
    parameter int TICK_DIV = 64
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_MAX);
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: accepts colour commands, fades each channel linearly to
// its target once per PWM period and drives active-low PWM LED pins.
//   clk, rst (async active-low)
//   cmd     - command channel (slave side)
//   busy    - fade in progress
//   led_r/g/b - registered active-low LED drive
module rgb_fade_ctrl
    import rgb_pkg::*;
#(
    parameter int TICK_DIV = 64
) (
    input  logic            clk,
    input  logic            rst,
    rgb_fade_ctrl_if.slave  cmd,
    output logic            busy,
    output logic            led_r,
    output logic            led_g,
    output logic            led_b
);

    fade_state_t          state;
    fade_state_t          state_nxt;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 wrap;
    logic                 accept;
    logic                 all_done;
    logic [RATE_BITS-1:0] rate_q;
    logic [PWM_BITS-1:0]  cmd_val [3];
    logic [PWM_BITS-1:0]  tgt     [3];
    logic [PWM_BITS-1:0]  cur     [3];
    logic [PWM_BITS-1:0]  nxt     [3];
    logic [PWM_BITS-1:0]  duty    [3];
    logic [2:0]           led_q;

    pwm_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt),
        .wrap    (wrap)
    );

    assign cmd_val[0] = cmd.cmd_r;
    assign cmd_val[1] = cmd.cmd_g;
    assign cmd_val[2] = cmd.cmd_b;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state == ST_FADE);
    assign accept        = cmd.cmd_valid && (state == ST_IDLE);

    always_comb begin
        all_done = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            nxt[i] = fade_step(cur[i], tgt[i], rate_q);
            if (nxt[i] != tgt[i])
                all_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && (cmd.cmd_rate != '0)) state_nxt = ST_FADE;
            ST_FADE: if (wrap && all_done)               state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // duty samples cur before this edge's update, so a wrap that coincides
    // with an accept or a fade step shows the new level one period later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_q <= '0;
            led_q  <= {3{LED_OFF}};
            for (int unsigned i = 0; i < 3; i++) begin
                tgt[i]  <= '0;
                cur[i]  <= '0;
                duty[i] <= '0;
            end
        end else begin
            if (accept)
                rate_q <= cmd.cmd_rate;
            for (int unsigned i = 0; i < 3; i++) begin
                if (accept) begin
                    tgt[i] <= cmd_val[i];
                    if (cmd.cmd_rate == '0)
                        cur[i] <= cmd_val[i];
                end else if ((state == ST_FADE) && wrap) begin
                    cur[i] <= nxt[i];
                end
                if (wrap)
                    duty[i] <= cur[i];
                led_q[i] <= !(pwm_cnt < duty[i]);
            end
        end
    end

    assign led_r = led_q[0];
    assign led_g = led_q[1];
    assign led_b = led_q[2];

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb_rgb_fade_ctrl: directed stimulus with a window scoreboard.
// Stimulus pushes the expected per-period LED low-clock counts (2*duty for
// TICK_DIV=2); the monitor counts low samples over each 512-clock window
// that follows a wrap and compares against the queue head.
module tb_rgb_fade_ctrl;

    logic clk;
    logic rst;
    logic busy;
    logic led_r;
    logic led_g;
    logic led_b;

    rgb_fade_ctrl_if cif ();

    rgb_fade_ctrl #(.TICK_DIV(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif),
        .busy  (busy),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b)
    );

    typedef struct {
        int p;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // posedges since last reset release; wrap edges are multiples of 512
    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", nm, act, exp, $time, n);
        end
    endtask

    task automatic push(input int p, input int r, input int g, input int b);
        exp_t e;
        e.p = p; e.r = 2 * r; e.g = 2 * g; e.b = 2 * b;
        q.push_back(e);
    endtask

    task automatic at_neg(input int k);
        while (n < k) @(negedge clk);
    endtask

    task automatic send(input int r, input int g, input int b, input int rate);
        cif.cmd_r     = 8'(r);
        cif.cmd_g     = 8'(g);
        cif.cmd_b     = 8'(b);
        cif.cmd_rate  = 4'(rate);
        cif.cmd_valid = 1'b1;
    endtask

    // monitor
    initial begin
        int   wr, wg, wb, p;
        exp_t e;
        wr = 0; wg = 0; wb = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr = 0; wg = 0; wb = 0;
            end else if (n >= 1) begin
                if (((n - 1) % 512) == 0) begin
                    wr = 0; wg = 0; wb = 0;
                end
                wr += (led_r == 1'b0) ? 1 : 0;
                wg += (led_g == 1'b0) ? 1 : 0;
                wb += (led_b == 1'b0) ? 1 : 0;
                if ((n % 512) == 0) begin
                    p = n / 512 - 1;
                    if (q.size() > 0 && q[0].p <= p) begin
                        e = q.pop_front();
                        if (e.p < p) begin
                            chk("window_index", p, e.p);
                        end else begin
                            chk($sformatf("p%0d_low_r", p), wr, e.r);
                            chk($sformatf("p%0d_low_g", p), wg, e.g);
                            chk($sformatf("p%0d_low_b", p), wb, e.b);
                        end
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        int cnt;
        rst = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_r = '0; cif.cmd_g = '0; cif.cmd_b = '0; cif.cmd_rate = '0;

        repeat (5) begin
            @(negedge clk);
            chk("reset_leds", {led_r, led_g, led_b}, 3'b111);
            chk("reset_ready", cif.cmd_ready, 1'b1);
            chk("reset_busy", busy, 1'b0);
        end
        push(0, 0, 0, 0);
        push(1, 0, 0, 0);
        push(2, 4, 0, 0);
        push(3, 8, 0, 0);
        push(4, 128, 0, 255);
        push(5, 200, 0, 0);
        push(6, 200, 0, 0);
        for (int k = 7; k <= 19; k++) push(k, 200 - 15 * (k - 6), 0, 0);
        push(20, 50, 60, 70);
        #2 rst = 1'b1;

        // fade r 0 -> 10 at rate 4: 4, 8, 10 on wraps 512, 1024, 1536
        at_neg(100);
        chk("idle_ready", cif.cmd_ready, 1'b1);
        send(10, 0, 0, 4);
        at_neg(101);
        cif.cmd_valid = 1'b0;
        chk("fade_busy", busy, 1'b1);
        chk("fade_ready_low", cif.cmd_ready, 1'b0);
        at_neg(1535);
        chk("busy_before_last_wrap", busy, 1'b1);
        at_neg(1536);
        chk("busy_after_last_wrap", busy, 1'b0);
        chk("ready_after_last_wrap", cif.cmd_ready, 1'b1);

        // immediate jump
        at_neg(1600);
        send(128, 0, 255, 0);
        at_neg(1601);
        cif.cmd_valid = 1'b0;
        chk("jump_busy", busy, 1'b0);
        chk("jump_ready", cif.cmd_ready, 1'b1);

        // jump to r=200 then fade down at rate 15 (14 wraps: 3072 .. 9728)
        at_neg(2100);
        send(200, 0, 0, 0);
        at_neg(2101);
        cif.cmd_valid = 1'b0;
        at_neg(2600);
        send(0, 0, 0, 15);
        at_neg(2601);
        cif.cmd_valid = 1'b0;
        chk("down_busy", busy, 1'b1);

        // held command during fade: first IDLE cycle is after edge 9728
        at_neg(3000);
        send(50, 60, 70, 0);
        cnt = 0;
        while (!cif.cmd_ready && cnt < 10000) begin
            @(negedge clk);
            cnt++;
        end
        chk("held_first_ready_edge", n, 9728);
        chk("held_busy_low", busy, 1'b0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("held_jump_busy", busy, 1'b0);

        // asynchronous reset mid-fade
        at_neg(10800);
        send(255, 255, 255, 1);
        at_neg(10801);
        cif.cmd_valid = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        at_neg(11000);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_leds", {led_r, led_g, led_b}, 3'b111);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_ready", cif.cmd_ready, 1'b1);
        chk("pending_before_reset", q.size(), 0);
        repeat (3) @(negedge clk);
        push(0, 0, 0, 0);
        push(1, 0, 0, 0);
        #2 rst = 1'b1;
        at_neg(5);
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_ready", cif.cmd_ready, 1'b1);
        at_neg(1030);
        chk("pending_windows", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_fade_ctrl.md
# rgb_fade_ctrl

Command-driven controller for the board RGB LED. Accepts colour targets over a valid/ready handshake, fades each channel linearly from its current intensity to the target at a programmable rate, and drives the three active-low LED pins with 8-bit PWM. It replaces free-running counter-bit blinking with sequenced, software-selectable colour and brightness.

## Interface
- `TICK_DIV`, default 64: clocks per PWM counter increment. Must be ≥1. PWM period = 256·TICK_DIV clocks.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_r`, `cmd_g`, `cmd_b`  in  8 each  target intensity; 0 = off, 255 = max.
- `cmd_rate`  in  4  fade step per PWM period; 0 = immediate jump.
- `busy`  out  1  fade in progress.
- `led_r`, `led_g`, `led_b`  out  1 each  active-low LED drive (1 = dark).

## Operation
- Timebase:
  - `presc` counts 0..TICK_DIV-1.
  - `pwm_cnt` (8-bit) increments when `presc` = TICK_DIV-1, wrapping 255→0.
  - `wrap` strobe = (`presc` = TICK_DIV-1) && (`pwm_cnt` = 255).
- Per channel x:
  - `tgt_x`: latched target.
  - `cur_x`: fade position.
  - `duty_x`: active duty. Loaded from pre-update `cur_x` on `wrap` only, so duty never changes mid-period (glitch-free).
- FSM has two states:
  - IDLE: `cmd_ready` = 1, `busy` = 0.
  - FADE: `cmd_ready` = 0, `busy` = 1.
- IDLE, on accept (`cmd_valid` && `cmd_ready`):
  - Latch `tgt_*` and the rate.
  - If rate = 0: `cur_*` ← target in the same edge; stay in IDLE.
  - Else go to FADE.
- FADE, on each `wrap`, per channel:
  - If |tgt−cur| ≤ rate: cur ← tgt.
  - Else cur ± rate toward tgt.
  - Compute in 9 bits; no overshoot, underflow or wrap.
- FADE exit: if all post-update `cur` equal `tgt` after a `wrap`, go to IDLE.
  - A command whose targets already equal `cur` with rate > 0 spends exactly one `wrap` in FADE.
- `cmd_valid` during FADE is ignored and must be held by the source until accepted.
- LED outputs: `led_x` is registered from `!(pwm_cnt < duty_x)`.
  - Duty 0 gives always dark.
  - Duty 255 gives lit for 255 of 256 steps.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - `presc`, `pwm_cnt`, `cur_*`, `tgt_*`, `duty_*` = 0.
  - State = IDLE, so `cmd_ready` = 1 and `busy` = 0.
  - `led_*` = 1.
- `cmd_ready` and `busy` are decoded from the state register (no combinational path from `cmd_valid`).
- Accept-to-state change takes 1 clock. `cmd_ready` is low the cycle after an accept with rate > 0.
- An immediate jump becomes visible on the LEDs at the first `wrap` after accept, plus 1 clock for the output register.
- An accept coinciding with `wrap`: `duty` loads the old `cur`; the new value appears one period later.
- Fade to completion takes ceil(max |tgt−cur| / rate) wraps. `busy` falls 1 clock after the final `wrap`.
- Reset mid-fade: all state returns to reset values immediately; no partial command is retained.

## Structure
- Shared package `rgb_pkg`:
  - `PWM_BITS` = 8.
  - `RATE_BITS` = 4.
  - FSM state encoding (IDLE = 0, FADE = 1).
  - `LED_OFF` = 1.
- Sub-module `pwm_timebase`:
  - Holds the prescaler and `pwm_cnt`.
  - Outputs `pwm_cnt` and `wrap`.
  - Parameter `TICK_DIV`.
- Top level holds the FSM, the three channel fade datapaths (generate loop or 3 instances of identical logic) and the output registers.

## Test plan
All scenarios use TICK_DIV = 2 (period 512 clocks).
- Reset, rst = 0 for 5 cycles, then release → `led_*` = 1 throughout; `cmd_ready` = 1; `busy` = 0; `led_*` stay 1 with no command.
- Command r=128, g=0, b=255, rate=0 → `busy` stays 0. After the next `wrap`+1: `led_r` low 256 of 512 clocks, `led_g` always 1, `led_b` low 510 of 512.
- Command r=10, rate=4, from cur_r=0 → cur_r = 4, 8, 10 on successive wraps; `busy` falls 1 clock after the third `wrap`; `cmd_ready` = 1 then.
- Command r=0, rate=15, from cur_r=200 → decrements 185, 170, … down to 5, then 0 on the 14th `wrap`; never wraps above 200.
- Second command with `cmd_valid` held during FADE → not accepted while `busy`; accepted on the first IDLE cycle; its targets are then latched.
- rst pulsed low mid-fade (asynchronously, between clock edges) → `led_*` = 1, `busy` = 0, `cmd_ready` = 1 before the next edge; `cur_*` = 0 after release.
